// File: rtl/m3_speed_sched_if.sv
// Command/status bundle between the operator front end and the m3 speed scheduler.
// master drives the command pulses and round strobe; slave returns run/speed/power state.
interface m3_speed_sched_if;
    logic        m3startI;
    logic        m3forceStopI;
    logic        m3invRotateI;
    logic        m3speedINCi;
    logic        m3speedDECi;
    logic        m3powerINCi;
    logic        m3powerDECi;
    logic        roundDoneI;
    logic        runO;
    logic        dirO;
    logic [31:0] dstRoundLenO;
    logic [3:0]  powerLevelO;
    logic        busyO;
    logic [2:0]  stateO;

    modport master (
        output m3startI, m3forceStopI, m3invRotateI, m3speedINCi, m3speedDECi,
               m3powerINCi, m3powerDECi, roundDoneI,
        input  runO, dirO, dstRoundLenO, powerLevelO, busyO, stateO
    );

    modport slave (
        input  m3startI, m3forceStopI, m3invRotateI, m3speedINCi, m3speedDECi,
               m3powerINCi, m3powerDECi, roundDoneI,
        output runO, dirO, dstRoundLenO, powerLevelO, busyO, stateO
    );
endinterface

// File: rtl/m3_speed_sched.sv
// Run/speed/power scheduler for one 3-phase motor channel: ramps the step length only at
// round boundaries and sequences reversal as slow-down, direction flip, re-accelerate.
module m3_speed_sched #(
    parameter logic [21:0] STEP_LEN_SLOW = 22'd2000000,
    parameter logic [21:0] STEP_LEN_FAST = 22'd20000,
    parameter logic [21:0] LEN_DELTA     = 22'd20000,
    parameter logic [21:0] RAMP_DELTA    = 22'd5000,
    parameter logic [3:0]  PWR_INIT      = 4'd4
) (
    input  logic              clkI,
    input  logic              nRstI,
    m3_speed_sched_if.slave   bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEL  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DECEL  = 3'd3;
    localparam logic [2:0] ST_FLIPDN = 3'd4;
    localparam logic [2:0] ST_FLIP   = 3'd5;

    logic [2:0]  state, state_nxt;
    logic [21:0] tgt_len, tgt_nxt;
    logic [21:0] cur_len, cur_nxt;
    logic [3:0]  pwr, pwr_nxt;
    logic        dir, dir_nxt;
    logic        run, busy;
    logic [22:0] tgt_sum;

    // Shorter step length = faster; holds when already at or past the target.
    function automatic logic [21:0] ramp_down(input logic [21:0] cur, input logic [21:0] tgt);
        if (cur <= tgt)                    return cur;
        else if (cur - tgt <= RAMP_DELTA)  return tgt;
        else                               return cur - RAMP_DELTA;
    endfunction

    function automatic logic [21:0] ramp_up(input logic [21:0] cur, input logic [21:0] tgt);
        if (cur >= tgt)                    return cur;
        else if (tgt - cur <= RAMP_DELTA)  return tgt;
        else                               return cur + RAMP_DELTA;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_len;
        dir_nxt   = dir;
        case (state)
            ST_IDLE: begin
                cur_nxt = STEP_LEN_SLOW;
                if (bus.m3startI)          state_nxt = ST_ACCEL;
                else if (bus.m3invRotateI) dir_nxt   = ~dir;
            end
            ST_ACCEL: begin
                if (bus.roundDoneI)        cur_nxt   = ramp_down(cur_len, tgt_len);
                if (bus.m3invRotateI)      state_nxt = ST_FLIPDN;
                else if (cur_len <= tgt_len) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.m3invRotateI)      state_nxt = ST_FLIPDN;
                else if (tgt_len < cur_len) state_nxt = ST_ACCEL;
                else if (tgt_len > cur_len) state_nxt = ST_DECEL;
            end
            ST_DECEL: begin
                if (bus.roundDoneI)        cur_nxt   = ramp_up(cur_len, tgt_len);
                if (bus.m3invRotateI)      state_nxt = ST_FLIPDN;
                else if (cur_len >= tgt_len) state_nxt = ST_RUN;
            end
            ST_FLIPDN: begin
                // The ramp ignores target edits here; it always heads to the flip length.
                if (bus.roundDoneI)        cur_nxt   = ramp_up(cur_len, STEP_LEN_SLOW);
                if (cur_len == STEP_LEN_SLOW) state_nxt = ST_FLIP;
            end
            ST_FLIP: begin
                dir_nxt   = ~dir;
                state_nxt = ST_ACCEL;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.m3forceStopI) begin
            state_nxt = ST_IDLE;
            cur_nxt   = STEP_LEN_SLOW;
            dir_nxt   = dir;
        end
    end

    // Target arithmetic is done 23 bits wide so neither direction can wrap before clamping.
    always_comb begin
        tgt_nxt = tgt_len;
        tgt_sum = {1'b0, tgt_len} + {1'b0, LEN_DELTA};
        if (bus.m3speedINCi && !bus.m3speedDECi) begin
            if ({1'b0, tgt_len} < {1'b0, STEP_LEN_FAST} + {1'b0, LEN_DELTA})
                tgt_nxt = STEP_LEN_FAST;
            else
                tgt_nxt = tgt_len - LEN_DELTA;
        end else if (bus.m3speedDECi && !bus.m3speedINCi) begin
            tgt_nxt = (tgt_sum > {1'b0, STEP_LEN_SLOW}) ? STEP_LEN_SLOW : tgt_sum[21:0];
        end
    end

    always_comb begin
        pwr_nxt = pwr;
        if (bus.m3powerINCi && !bus.m3powerDECi && pwr != 4'd15)
            pwr_nxt = pwr + 4'd1;
        else if (bus.m3powerDECi && !bus.m3powerINCi && pwr != 4'd0)
            pwr_nxt = pwr - 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state   <= ST_IDLE;
            tgt_len <= STEP_LEN_SLOW;
            cur_len <= STEP_LEN_SLOW;
            pwr     <= PWR_INIT;
            dir     <= 1'b0;
            run     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt_len <= tgt_nxt;
            cur_len <= cur_nxt;
            pwr     <= pwr_nxt;
            dir     <= dir_nxt;
            run     <= (state_nxt != ST_IDLE);
            busy    <= (state_nxt == ST_ACCEL) || (state_nxt == ST_DECEL) ||
                       (state_nxt == ST_FLIPDN) || (state_nxt == ST_FLIP);
        end
    end

    assign bus.runO         = run;
    assign bus.dirO         = dir;
    assign bus.dstRoundLenO = {10'd0, cur_len};
    assign bus.powerLevelO  = pwr;
    assign bus.busyO        = busy;
    assign bus.stateO       = state;
endmodule

// File: tb/tb_m3_speed_sched.sv
// Directed bench for m3_speed_sched with small lengths: a vector table for the main
// run/reverse/stop flow plus hand sequences for reset, power and speed saturation.
module tb_m3_speed_sched;
    localparam logic [7:0] C_NONE  = 8'h00;
    localparam logic [7:0] C_STOP  = 8'h80;
    localparam logic [7:0] C_START = 8'h40;
    localparam logic [7:0] C_INV   = 8'h20;
    localparam logic [7:0] C_SINC  = 8'h10;
    localparam logic [7:0] C_SDEC  = 8'h08;
    localparam logic [7:0] C_PINC  = 8'h04;
    localparam logic [7:0] C_PDEC  = 8'h02;
    localparam logic [7:0] C_RD    = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] cmd;
        logic       run;
        logic       dir;
        int         len;
        int         pwr;
        logic       busy;
        logic [2:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t vecs[$];

    m3_speed_sched_if bus();

    m3_speed_sched #(
        .STEP_LEN_SLOW(22'd100),
        .STEP_LEN_FAST(22'd20),
        .LEN_DELTA    (22'd30),
        .RAMP_DELTA   (22'd10),
        .PWR_INIT     (4'd4)
    ) dut (
        .clkI (clk),
        .nRstI(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cmd(input logic [7:0] c);
        bus.m3forceStopI = c[7];
        bus.m3startI     = c[6];
        bus.m3invRotateI = c[5];
        bus.m3speedINCi  = c[4];
        bus.m3speedDECi  = c[3];
        bus.m3powerINCi  = c[2];
        bus.m3powerDECi  = c[1];
        bus.roundDoneI   = c[0];
    endtask

    // Present a command for exactly one clock and sample outputs 1 time unit after the edge.
    task automatic cyc(input logic [7:0] c);
        set_cmd(c);
        @(posedge clk);
        #1;
        set_cmd(C_NONE);
    endtask

    task automatic chk_sl(input string name, input int st, input int len);
        check({name, ".state"}, 32'(bus.stateO), 32'(st));
        check({name, ".len"}, bus.dstRoundLenO, 32'(len));
    endtask

    task automatic add(input string n, input logic [7:0] c, input logic r, input logic d,
                       input int l, input int p, input logic b, input logic [2:0] s);
        vec_t v;
        v.name = n; v.cmd = c; v.run = r; v.dir = d; v.len = l; v.pwr = p; v.busy = b; v.st = s;
        vecs.push_back(v);
    endtask

    initial begin
        int e;
        set_cmd(C_NONE);

        // Accelerate to target 40, reverse, re-accelerate, force stop, restart.
        add("start",     C_START,         1, 0, 100, 4, 1, 1);
        add("inc1",      C_SINC,          1, 0, 100, 4, 0, 2);
        add("inc2",      C_SINC,          1, 0, 100, 4, 1, 1);
        for (int i = 1; i <= 6; i++)
            add($sformatf("acc%0d", 100 - 10 * i), C_RD, 1, 0, 100 - 10 * i, 4, 1, 1);
        add("run40",     C_NONE,          1, 0, 40,  4, 0, 2);
        add("inv",       C_INV,           1, 0, 40,  4, 1, 4);
        add("fdn50",     C_RD,            1, 0, 50,  4, 1, 4);
        add("fdn60_inv", C_INV | C_RD,    1, 0, 60,  4, 1, 4);
        for (int i = 7; i <= 10; i++)
            add($sformatf("fdn%0d", 10 * i), C_RD, 1, 0, 10 * i, 4, 1, 4);
        add("flip",      C_NONE,          1, 0, 100, 4, 1, 5);
        add("reaccel",   C_NONE,          1, 1, 100, 4, 1, 1);
        add("racc90",    C_RD,            1, 1, 90,  4, 1, 1);
        add("racc80",    C_RD,            1, 1, 80,  4, 1, 1);
        add("racc70",    C_RD,            1, 1, 70,  4, 1, 1);
        add("stop_rd",   C_STOP | C_RD,   0, 1, 100, 4, 0, 0);
        add("restart",   C_START,         1, 1, 100, 4, 1, 1);
        add("start_ign", C_START,         1, 1, 100, 4, 1, 1);
        add("ramp90",    C_RD,            1, 1, 90,  4, 1, 1);
        add("pwr_both",  C_PINC | C_PDEC, 1, 1, 90,  4, 1, 1);
        add("pwr_inc",   C_PINC,          1, 1, 90,  5, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst.run",   32'(bus.runO), 32'd0);
        check("rst.dir",   32'(bus.dirO), 32'd0);
        check("rst.busy",  32'(bus.busyO), 32'd0);
        check("rst.pwr",   32'(bus.powerLevelO), 32'd4);
        chk_sl("rst", 0, 100);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(C_NONE);
        chk_sl("idle", 0, 100);

        foreach (vecs[i]) begin
            cyc(vecs[i].cmd);
            check({vecs[i].name, ".run"},  32'(bus.runO),        32'(vecs[i].run));
            check({vecs[i].name, ".dir"},  32'(bus.dirO),        32'(vecs[i].dir));
            check({vecs[i].name, ".pwr"},  32'(bus.powerLevelO), 32'(vecs[i].pwr));
            check({vecs[i].name, ".busy"}, 32'(bus.busyO),       32'(vecs[i].busy));
            chk_sl(vecs[i].name, 32'(vecs[i].st), vecs[i].len);
        end

        // Reset in the middle of a ramp must restore everything without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.run",  32'(bus.runO), 32'd0);
        check("arst.dir",  32'(bus.dirO), 32'd0);
        check("arst.busy", 32'(bus.busyO), 32'd0);
        check("arst.pwr",  32'(bus.powerLevelO), 32'd4);
        chk_sl("arst", 0, 100);
        @(negedge clk);
        rst_n = 1'b1;

        // Direction toggles directly in IDLE; start outranks invRotate.
        cyc(C_INV);
        check("idle_inv1.dir", 32'(bus.dirO), 32'd1);
        cyc(C_INV);
        check("idle_inv2.dir", 32'(bus.dirO), 32'd0);
        cyc(C_START | C_INV);
        check("start_inv.dir", 32'(bus.dirO), 32'd0);
        chk_sl("start_inv", 1, 100);
        cyc(C_STOP);
        chk_sl("stop_idle", 0, 100);

        // Power saturation at both ends, then simultaneous INC+DEC at a mid level.
        for (int i = 1; i <= 12; i++) begin
            e = (4 + i > 15) ? 15 : 4 + i;
            cyc(C_PINC);
            check($sformatf("pinc%0d", i), 32'(bus.powerLevelO), 32'(e));
        end
        for (int i = 1; i <= 20; i++) begin
            e = (15 - i < 0) ? 0 : 15 - i;
            cyc(C_PDEC);
            check($sformatf("pdec%0d", i), 32'(bus.powerLevelO), 32'(e));
        end
        cyc(C_PINC);
        check("pinc_from0", 32'(bus.powerLevelO), 32'd1);
        cyc(C_PINC | C_PDEC);
        check("pwr_both_mid", 32'(bus.powerLevelO), 32'd1);

        // Target 70, INC+DEC ignored, then ramp confirms target stayed at 70.
        cyc(C_SINC);
        chk_sl("idle_sinc", 0, 100);
        cyc(C_SINC | C_SDEC);
        cyc(C_START);
        chk_sl("s_start", 1, 100);
        for (int i = 1; i <= 3; i++) begin
            cyc(C_RD);
            chk_sl($sformatf("s_acc%0d", i), 1, 100 - 10 * i);
        end
        cyc(C_NONE);
        chk_sl("s_run70", 2, 70);

        // Four INCs from 70 saturate at FAST=20; ramp must stop at 20, not below.
        repeat (4) cyc(C_SINC);
        chk_sl("s_sat", 1, 70);
        for (int i = 1; i <= 5; i++) begin
            cyc(C_RD);
            chk_sl($sformatf("s_sacc%0d", i), 1, 70 - 10 * i);
        end
        cyc(C_NONE);
        chk_sl("s_run20", 2, 20);
        check("s_run20.busy", 32'(bus.busyO), 32'd0);

        // One DEC from 20 gives 50: RUN -> DECEL, ramp 30,40,50, back to RUN.
        cyc(C_SDEC);
        chk_sl("s_dec", 2, 20);
        cyc(C_NONE);
        chk_sl("s_decel", 3, 20);
        check("s_decel.busy", 32'(bus.busyO), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(C_RD);
            chk_sl($sformatf("s_dacc%0d", i), 3, 20 + 10 * i);
        end
        cyc(C_NONE);
        chk_sl("s_run50", 2, 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
